// File: rtl/spike_pulse_gen.sv
`default_nettype none
// ============================================================================
// spike_pulse_gen : pairs an asynchronous spike strobe with a synchronous
//                   neuron index and emits it as a pulse plus refractory time.
// Revision        : 1.0
// ============================================================================
module spike_pulse_gen #(
  parameter int P_N         = 8,
  parameter int P_WINDOW    = 3,
  parameter int P_PULSE_LEN = 1,
  parameter int P_REFRACT   = 2,
  parameter int P_CNT_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_spike,
  input  logic [P_N:1]       i_index,
  output logic [P_N:1]       o_spike,
  output logic               o_valid,
  output logic               o_busy,
  output logic [P_CNT_W-1:0] o_drop_cnt
);

  localparam int C_MAX_A = (P_WINDOW > P_PULSE_LEN) ? P_WINDOW : P_PULSE_LEN;
  localparam int C_MAX   = (C_MAX_A > P_REFRACT) ? C_MAX_A : P_REFRACT;
  localparam int C_CW    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  localparam logic [C_CW-1:0]    C_WIN_LAST   = C_CW'(P_WINDOW - 1);
  localparam logic [C_CW-1:0]    C_PULSE_LAST = C_CW'(P_PULSE_LEN - 1);
  localparam logic [C_CW-1:0]    C_REFR_LAST  = C_CW'((P_REFRACT > 0) ? P_REFRACT - 1 : 0);
  localparam logic [C_CW-1:0]    C_CNT_ONE    = C_CW'(1);
  localparam logic [P_CNT_W-1:0] C_DROP_ONE   = P_CNT_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_FIRE    = 2'd2;
  localparam logic [1:0] S_REFRACT = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [P_N:1]       idx_q, idx_d;
  logic [C_CW-1:0]    cnt_q, cnt_d;
  logic [P_CNT_W-1:0] drop_q, drop_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic               w_evt;
  logic               w_index_nz;
  logic               w_drop_inc;

  assign w_evt      = s2_q & ~s3_q;
  assign w_index_nz = |i_index;

  always_comb begin
    s1_d       = i_spike;
    s2_d       = s1_q;
    s3_d       = s2_q;
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    w_drop_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_evt) begin
          cnt_d = '0;
          if (w_index_nz) begin
            idx_d   = i_index;
            state_d = S_FIRE;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        // A late index beats both the timeout and a re-strobe on the same edge.
        if (w_index_nz) begin
          idx_d   = i_index;
          cnt_d   = '0;
          state_d = S_FIRE;
        end else if (w_evt) begin
          cnt_d = '0;
        end else if (cnt_q == C_WIN_LAST) begin
          state_d    = S_IDLE;
          w_drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_FIRE: begin
        w_drop_inc = w_evt;
        if (cnt_q == C_PULSE_LAST) begin
          cnt_d   = '0;
          state_d = (P_REFRACT > 0) ? S_REFRACT : S_IDLE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_REFRACT: begin
        w_drop_inc = w_evt;
        if (cnt_q == C_REFR_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    drop_d = (w_drop_inc && (drop_q != '1)) ? drop_q + C_DROP_ONE : drop_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

  assign o_spike    = (state_q == S_FIRE) ? idx_q : '0;
  assign o_valid    = (state_q == S_FIRE) && (cnt_q == '0);
  assign o_busy     = (state_q != S_IDLE);
  assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_pulse_gen.sv
`default_nettype none
// ============================================================================
// tb_spike_pulse_gen : directed bench with expected-pulse scoreboards for three
//                      parameterisations of spike_pulse_gen.
// Revision           : 1.0
// ============================================================================
module tb_spike_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // A: defaults
  logic        rst_a, spk_a, valid_a, busy_a;
  logic [8:1]  idx_a, spike_a;
  logic [7:0]  drop_a;
  // B: short drop counter, longer pulse
  logic        rst_b, spk_b, valid_b, busy_b;
  logic [8:1]  idx_b, spike_b;
  logic [1:0]  drop_b;
  // C: 16 neurons, 4-cycle pulse
  logic        rst_c, spk_c, valid_c, busy_c;
  logic [16:1] idx_c, spike_c;
  logic [7:0]  drop_c;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_c[$];

  spike_pulse_gen u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_spike(spk_a), .i_index(idx_a),
    .o_spike(spike_a), .o_valid(valid_a), .o_busy(busy_a), .o_drop_cnt(drop_a)
  );

  spike_pulse_gen #(.P_CNT_W(2), .P_PULSE_LEN(2), .P_REFRACT(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_spike(spk_b), .i_index(idx_b),
    .o_spike(spike_b), .o_valid(valid_b), .o_busy(busy_b), .o_drop_cnt(drop_b)
  );

  spike_pulse_gen #(.P_N(16), .P_PULSE_LEN(4)) u_dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_spike(spk_c), .i_index(idx_c),
    .o_spike(spike_c), .o_valid(valid_c), .o_busy(busy_c), .o_drop_cnt(drop_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: every o_valid must match the oldest predicted index.
  always @(negedge clk) begin
    if (valid_a) begin
      chk("sb_a_pending", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) chk("sb_a_spike", 32'(spike_a), 32'(q_a.pop_front()));
    end
    if (valid_b) begin
      chk("sb_b_pending", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) chk("sb_b_spike", 32'(spike_b), 32'(q_b.pop_front()));
    end
    if (valid_c) begin
      chk("sb_c_pending", 32'(q_c.size() != 0), 32'd1);
      if (q_c.size() != 0) chk("sb_c_spike", 32'(spike_c), 32'(q_c.pop_front()));
    end
  end

  initial begin
    int e;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    spk_a = 1'b0; spk_b = 1'b0; spk_c = 1'b0;
    idx_a = '0;   idx_b = '0;   idx_c = '0;

    // Reset with the strobe toggling
    for (int i = 0; i < 3; i++) begin
      spk_a = ~spk_a;
      tick();
      chk("rst_spike", 32'(spike_a), 32'd0);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_drop",  32'(drop_a),  32'd0);
    end
    spk_a = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_busy", 32'(busy_a), 32'd0);
    end

    // Direct fire
    idx_a = 8'h24; spk_a = 1'b1;
    tick();
    chk("dir_busy_k", 32'(busy_a), 32'd0);
    tick();
    chk("dir_spike_k1", 32'(spike_a), 32'd0);
    q_a.push_back(16'h0024);
    tick();
    chk("dir_spike", 32'(spike_a), 32'h24);
    chk("dir_valid", 32'(valid_a), 32'd1);
    chk("dir_busy",  32'(busy_a),  32'd1);
    spk_a = 1'b0;
    tick();
    chk("dir_len",   32'(spike_a), 32'd0);
    chk("dir_vonce", 32'(valid_a), 32'd0);
    chk("dir_busy2", 32'(busy_a),  32'd1);
    tick();
    chk("dir_busy3", 32'(busy_a), 32'd1);
    tick();
    chk("dir_busy_end", 32'(busy_a), 32'd0);
    chk("dir_drop",     32'(drop_a), 32'd0);
    idx_a = '0;

    // Late index on the 2nd ARMED cycle
    spk_a = 1'b1;
    tick(); tick(); tick();
    chk("late_armed", 32'(busy_a),  32'd1);
    chk("late_sp0",   32'(spike_a), 32'd0);
    spk_a = 1'b0;
    tick();
    chk("late_sp1", 32'(spike_a), 32'd0);
    idx_a = 8'h01;
    q_a.push_back(16'h0001);
    tick();
    chk("late_spike", 32'(spike_a), 32'h01);
    chk("late_valid", 32'(valid_a), 32'd1);
    idx_a = '0;
    tick(); tick(); tick();
    chk("late_idle", 32'(busy_a), 32'd0);
    chk("late_drop", 32'(drop_a), 32'd0);

    // Timeout with index held at zero
    spk_a = 1'b1;
    tick(); tick();
    spk_a = 1'b0;
    tick();
    chk("to_armed", 32'(busy_a), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("to_spike", 32'(spike_a), 32'd0);
      chk("to_drop0", 32'(drop_a),  32'd0);
      chk("to_busy",  32'(busy_a),  32'd1);
    end
    tick();
    chk("to_idle",  32'(busy_a),  32'd0);
    chk("to_drop1", 32'(drop_a),  32'd1);
    chk("to_spk_e", 32'(spike_a), 32'd0);

    // Index arriving on the final ARMED cycle still fires, no drop
    spk_a = 1'b1;
    tick(); tick();
    spk_a = 1'b0;
    tick(); tick(); tick();
    chk("fin_armed", 32'(busy_a), 32'd1);
    idx_a = 8'h42;
    q_a.push_back(16'h0042);
    tick();
    chk("fin_spike", 32'(spike_a), 32'h42);
    chk("fin_drop",  32'(drop_a),  32'd1);
    idx_a = '0;
    tick(); tick(); tick();
    chk("fin_idle", 32'(busy_a), 32'd0);

    // Back-to-back strobes at the documented minimum spacing: no drops
    idx_a = 8'h11;
    for (int j = 0; j < 2; j++) begin
      spk_a = 1'b1;
      q_a.push_back(16'h0011);
      tick(); tick();
      spk_a = 1'b0;
      tick(); tick(); tick();
    end
    tick(); tick();
    chk("b2b_idle", 32'(busy_a), 32'd0);
    chk("b2b_drop", 32'(drop_a), 32'd1);
    idx_a = '0;

    // Strobe held high across reset release gives exactly one event
    rst_a = 1'b1; spk_a = 1'b1; idx_a = 8'h24;
    tick(); tick();
    chk("hold_rst_drop", 32'(drop_a), 32'd0);
    rst_a = 1'b0;
    tick(); tick();
    q_a.push_back(16'h0024);
    tick();
    chk("hold_spike", 32'(spike_a), 32'h24);
    chk("hold_valid", 32'(valid_a), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("hold_idle", 32'(busy_a), 32'd0);
    chk("hold_drop", 32'(drop_a), 32'd0);
    spk_a = 1'b0; idx_a = '0;

    // Refractory drops every other strobe; 2-bit counter saturates at 3
    idx_b = 8'h80;
    for (int j = 0; j < 8; j++) begin
      spk_b = 1'b1;
      if (j % 2 == 0) q_b.push_back(16'h0080);
      tick();
      spk_b = 1'b0;
      tick(); tick();
      e = (j + 1) / 2;
      if (e > 3) e = 3;
      chk("rf_drop", 32'(drop_b), 32'(e));
      if (j % 2 == 0) chk("rf_spike", 32'(spike_b), 32'h80);
    end
    for (int i = 0; i < 6; i++) tick();
    chk("rf_idle", 32'(busy_b), 32'd0);
    chk("rf_sat",  32'(drop_b), 32'd3);

    // Reset on the 2nd FIRE cycle of a 16-bit, 4-cycle pulse
    idx_c = 16'h8001; spk_c = 1'b1;
    tick();
    spk_c = 1'b0;
    tick();
    q_c.push_back(16'h8001);
    tick();
    chk("mr_spike1", 32'(spike_c), 32'h8001);
    chk("mr_valid1", 32'(valid_c), 32'd1);
    tick();
    chk("mr_spike2", 32'(spike_c), 32'h8001);
    chk("mr_valid2", 32'(valid_c), 32'd0);
    rst_c = 1'b1;
    tick();
    chk("mr_abort", 32'(spike_c), 32'd0);
    chk("mr_busy",  32'(busy_c),  32'd0);
    chk("mr_valid", 32'(valid_c), 32'd0);
    rst_c = 1'b0;
    tick();
    spk_c = 1'b1;
    tick();
    spk_c = 1'b0;
    tick();
    q_c.push_back(16'h8001);
    tick();
    chk("mr2_valid", 32'(valid_c), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr2_hold", 32'(spike_c), 32'h8001);
    end
    tick();
    chk("mr2_end",  32'(spike_c), 32'd0);
    chk("mr2_refr", 32'(busy_c),  32'd1);
    tick(); tick();
    chk("mr2_idle", 32'(busy_c), 32'd0);
    chk("mr2_drop", 32'(drop_c), 32'd0);

    tick(); tick();
    chk("sb_a_empty", 32'(q_a.size()), 32'd0);
    chk("sb_b_empty", 32'(q_b.size()), 32'd0);
    chk("sb_c_empty", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
